// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the MIPS instruction fetch slice
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        WAIT,
        CAPTURE,
        HOLD,
        TRAP
    } fetch_state_t;

    localparam int          WORD_BYTES = 4;
    localparam int          IMEM_WORDS = 1024;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - {pc,instr} buffer between fetch and decode, with flush
// Head outputs hold the last presented entry while the buffer is empty.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head_entry
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    fetch_entry_t   mem [FIFO_DEPTH];
    fetch_entry_t   last_entry;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head_entry = empty ? last_entry : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_entry <= '{pc: 32'h0, instr: INSTR_NOP};
        end else begin
            if (!empty)
                last_entry <= mem[rd_ptr[AW-1:0]];
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (do_pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, imem wait/capture FSM and decode handoff
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect traps instead of being silently aligned.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_WAIT   = 1,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    localparam int            WCW       = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT - 1);

    fetch_state_t   state;
    logic [WCW-1:0] wait_cnt;
    logic [31:0]    pc;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           can_push;
    logic           push;
    fetch_entry_t   head;

    assign imem_address = pc;
    assign instr_valid  = !fifo_empty;
    assign instr_pc     = head.pc;
    assign instr_data   = head.instr;

    assign pop      = instr_valid && instr_ready;
    assign can_push = !fifo_full || pop;
    assign push     = !redirect_valid && ((state == CAPTURE) || (state == HOLD)) && can_push;

    fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry ('{pc: pc, instr: imem_instruction}),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_entry (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= word_align(RESET_PC);
            state    <= WAIT;
            wait_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= word_align(redirect_target);
            wait_cnt <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            state    <= (redirect_target[1:0] != 2'b00) ? TRAP : WAIT;
`else
            state    <= WAIT;
`endif
        end else begin
            case (state)
                WAIT: begin
                    if (wait_cnt == WAIT_LAST)
                        state <= CAPTURE;
                    else
                        wait_cnt <= wait_cnt + WCW'(1);
                end
                CAPTURE, HOLD: begin
                    if (can_push) begin
                        pc       <= pc + 32'(WORD_BYTES);
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end else begin
                        state <= HOLD;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            misalign_q <= 1'b0;
        else if (redirect_valid && (redirect_target[1:0] != 2'b00))
            misalign_q <= 1'b1;
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    import mips_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        misalign_err;

    logic [31:0] mem [IMEM_WORDS];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_address[11:2]];

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .misalign_err     (misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[11:2]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic rdy);
        reset_n         = 1'b0;
        instr_ready     = rdy;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_addr", imem_address, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_data", instr_data, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        @(negedge clk);
        redirect_valid  = 1'b0;
        check("redir_flush", 32'(instr_valid), 32'h0);
    endtask

    // Consume one instruction with ready held high, bounded wait.
    task automatic expect_next(input string name, input logic [31:0] exp_pc);
        bit found = 0;
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid) begin
                found = 1;
                check({name, "_pc"}, instr_pc, exp_pc);
                check({name, "_data"}, instr_data, mem_word(exp_pc));
            end
            @(negedge clk);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: got no instr_valid within 20 cycles expected pc %h", name, exp_pc);
        end
    endtask

    typedef struct {
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        redir;
        logic        prev_redir;
        int          hs_count;
        int          vcount;

        for (int i = 0; i < IMEM_WORDS; i++)
            mem[i] = $urandom;

        // One word every 2 cycles with ready held high, observed after each edge.
        vt[0] = '{1'b0, 32'h0, 32'h0};
        vt[1] = '{1'b1, 32'h0, 32'h4};
        vt[2] = '{1'b0, 32'h0, 32'h4};
        vt[3] = '{1'b1, 32'h4, 32'h8};
        vt[4] = '{1'b0, 32'h4, 32'h8};
        vt[5] = '{1'b1, 32'h8, 32'hC};
        vt[6] = '{1'b0, 32'h8, 32'hC};
        vt[7] = '{1'b1, 32'hC, 32'h10};

        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_valid[%0d]", k), 32'(instr_valid), 32'(vt[k].exp_valid));
            check($sformatf("t1_pc[%0d]", k), instr_pc, vt[k].exp_pc);
            check($sformatf("t1_addr[%0d]", k), imem_address, vt[k].exp_addr);
            if (vt[k].exp_valid)
                check($sformatf("t1_data[%0d]", k), instr_data, mem_word(vt[k].exp_pc));
        end

        // Back-pressure: buffer fills with pc 0,4 and fetch parks at 8.
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        check("t2_valid", 32'(instr_valid), 32'h1);
        check("t2_head", instr_pc, 32'h0);
        check("t2_addr", imem_address, 32'h8);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_stream_valid[%0d]", i), 32'(instr_valid), 32'h1);
            check($sformatf("t2_stream_pc[%0d]", i), instr_pc, 32'(4 * i));
            @(negedge clk);
        end

        // Redirect with a full buffer and a parked fetch.
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        do_redirect(32'h40);
        check("t3_addr", imem_address, 32'h40);
        expect_next("t3_first", 32'h40);

        // Address wrap-around.
        do_redirect(32'hFFFF_FFF8);
        expect_next("t4_a", 32'hFFFF_FFF8);
        expect_next("t4_b", 32'hFFFF_FFFC);
        expect_next("t4_c", 32'h0000_0000);

        // Misaligned redirect.
        do_redirect(32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t5_misalign", 32'(misalign_err), 32'h1);
        check("t5_addr", imem_address, 32'h40);
        vcount = 0;
        instr_ready = 1'b1;
        repeat (10) begin
            if (instr_valid) vcount++;
            @(negedge clk);
        end
        check("t5_trap_pushes", 32'(vcount), 32'h0);
        do_redirect(32'h80);
        expect_next("t5_resume", 32'h80);
        check("t5_sticky", 32'(misalign_err), 32'h1);
`else
        check("t5_misalign", 32'(misalign_err), 32'h0);
        expect_next("t5_resume", 32'h40);
`endif

        // Asynchronous reset mid-WAIT with one entry buffered.
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_valid", 32'(instr_valid), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_valid", 32'(instr_valid), 32'h0);
        check("t6_addr", imem_address, 32'h0);
        @(negedge clk);

        // Random ready/redirect traffic against an in-order stream model.
        do_reset(1'b1);
        exp_pc     = 32'h0;
        prev_redir = 1'b0;
        hs_count   = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_redir)
                check("rnd_flush", 32'(instr_valid), 32'h0);
            if (imem_address[1:0] != 2'b00)
                check("rnd_addr_align", 32'(imem_address[1:0]), 32'h0);
            redir = ($urandom_range(0, 23) == 0);
            tgt   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt   = tgt & ~32'h3;
`endif
            instr_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid  = redir;
            redirect_target = tgt;
            if (instr_valid && instr_ready) begin
                check("rnd_pc", instr_pc, exp_pc);
                check("rnd_data", instr_data, mem_word(exp_pc));
                exp_pc = exp_pc + 32'h4;
                hs_count++;
            end
            if (redir)
                exp_pc = tgt & ~32'h3;
            prev_redir = redir;
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        checks++;
        if (hs_count < 300) begin
            errors++;
            $display("FAIL rnd_progress: got %0d transfers required at least 300", hs_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
